pcp_to_dest: RTL and testbench



---
 rtl/pcp_to_dest.sv | 140 ++++++++++++++
 tb/tb_pcp_to_dest.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcp_to_dest.sv
// VLAN PCP classifier: buffers up to 15 header bytes, decides a 2-bit class, then streams the frame with a fixed tdest.
// Optional per-class frame counters on stat_frames when PCP_TO_DEST_STATS_EN is defined.
module pcp_to_dest #(
  parameter logic [15:0] PCP_MAP       = 16'hFA50,
  parameter logic [1:0]  DEFAULT_CLASS = 2'd0,
  parameter logic [15:0] TPID          = 16'h8100
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [7:0]   m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [1:0]   m_axis_tdest
`ifdef PCP_TO_DEST_STATS_EN
  ,output logic [127:0] stat_frames
`endif
);

  typedef enum logic [1:0] {FILL, DRAIN, PASS} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hdr_q [15];
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  class_q, class_d;
  logic        frame_end_q, frame_end_d;
  logic        init_q;
  logic        fill_wr, fill_done, rd_last;
  logic [1:0]  class_dec;
  logic [2:0]  pcp;

  // Upstream is only told ready once reset has been released for a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_q <= 1'b0;
    else       init_q <= 1'b1;
  end

  assign fill_wr   = (state_q == FILL) && init_q && s_axis_tvalid;
  assign fill_done = fill_wr && (s_axis_tlast || cnt_q == 4'd14);
  assign rd_last   = (rd_q == len_q - 4'd1);
  assign pcp       = s_axis_tdata[7:5];

  // Byte 14 is never stored before the decision; it comes straight off the input beat.
  always_comb begin
    class_dec = DEFAULT_CLASS;
    if (cnt_q == 4'd14 && {hdr_q[12], hdr_q[13]} == TPID)
      class_dec = PCP_MAP[{pcp, 1'b0} +: 2];
  end

  always_ff @(posedge clk) begin
    if (fill_wr) hdr_q[cnt_q] <= s_axis_tdata;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    len_d         = len_q;
    class_d       = class_q;
    frame_end_d   = frame_end_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    case (state_q)
      FILL: begin
        s_axis_tready = init_q;
        if (fill_wr) begin
          cnt_d = cnt_q + 4'd1;
          if (fill_done) begin
            state_d     = DRAIN;
            len_d       = cnt_q + 4'd1;
            frame_end_d = s_axis_tlast;
            class_d     = class_dec;
            cnt_d       = 4'd0;
            rd_d        = 4'd0;
          end
        end
      end
      DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[rd_q];
        m_axis_tlast  = frame_end_q && rd_last;
        if (m_axis_tready) begin
          rd_d = rd_q + 4'd1;
          if (rd_last) begin
            rd_d    = 4'd0;
            state_d = frame_end_q ? FILL : PASS;
          end
        end
      end
      PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      rd_q        <= 4'd0;
      len_q       <= 4'd0;
      class_q     <= DEFAULT_CLASS;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      len_q       <= len_d;
      class_q     <= class_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign m_axis_tdest = class_q;

`ifdef PCP_TO_DEST_STATS_EN
  logic [3:0][31:0] stat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          stat_q            <= '0;
    else if (fill_done) stat_q[class_dec] <= stat_q[class_dec] + 32'd1;
  end

  assign stat_frames = stat_q;
`endif

endmodule

// File: tb/tb_pcp_to_dest.sv
// Randomized bench for pcp_to_dest: a frame-level model predicts every output beat and the class per frame.
module tb_pcp_to_dest;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic [1:0] m_tdest;
  logic [7:0] a_tdata;
  logic       a_tvalid, a_sready, a_tlast;
  logic [1:0] a_tdest;
`ifdef PCP_TO_DEST_STATS_EN
  logic [127:0] stat, a_stat;
`endif

  always #5 clk = ~clk;

  pcp_to_dest dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tdest(m_tdest)
`ifdef PCP_TO_DEST_STATS_EN
    ,.stat_frames(stat)
`endif
  );

  // Alternate mapping: only PCP0 maps to class 3, untagged goes to class 1.
  pcp_to_dest #(.PCP_MAP(16'h0003), .DEFAULT_CLASS(2'd1)) dut_alt (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_sready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(a_tlast),
    .m_axis_tdest(a_tdest)
`ifdef PCP_TO_DEST_STATS_EN
    ,.stat_frames(a_stat)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] dst;
    logic [1:0] alt;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  int    rdy_mode = 2;
  beat_t expq[$];
  beat_t b;
  int    cls_cnt[4];
  logic  stall_q = 1'b0;
  logic [10:0] prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] cls(input logic [7:0] f[$], input logic [15:0] map, input logic [1:0] dflt);
    logic [2:0] p;
    if (f.size() >= 15 && f[12] == 8'h81 && f[13] == 8'h00) begin
      p = f[14][7:5];
      return map[2*p +: 2];
    end
    return dflt;
  endfunction

  // tag: 0 = EtherType 0800, 1 = TPID 8100, 2 = near miss 8101, 3 = random bytes
  function automatic void mk(output logic [7:0] f[$], input int len, input int tag, input logic [2:0] p);
    f = {};
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
    if (tag != 3) begin
      if (len > 12) f[12] = (tag == 0) ? 8'h08 : 8'h81;
      if (len > 13) f[13] = (tag == 2) ? 8'h01 : 8'h00;
    end
    if (len > 14) f[14] = {p, 5'($urandom)};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    logic [1:0] c, a;
    beat_t e;
    c = cls(f, 16'hFA50, 2'd0);
    a = cls(f, 16'h0003, 2'd1);
    cls_cnt[c]++;
    foreach (f[i]) begin
      e.d = f[i]; e.l = (i == f.size() - 1); e.dst = c; e.alt = a;
      expq.push_back(e);
    end
    foreach (f[i]) begin
      send_byte(f[i], i == f.size() - 1);
      if (gaps && i != f.size() - 1)
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", expq.size(), 32'd0);
  endtask

  task automatic chk_stats();
`ifdef PCP_TO_DEST_STATS_EN
    for (int c = 0; c < 4; c++) chk("stat", stat[32*c +: 32], cls_cnt[c]);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = ($urandom_range(0, 3) != 0);
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'b1;
        default: m_tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rstn) stall_q = 1'b0;
    else begin
      if (stall_q) chk("stable", {m_tvalid, m_tdata, m_tlast, m_tdest}, {1'b1, prev});
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          b = expq.pop_front();
          chk("beat", {m_tdata, m_tlast, m_tdest}, {b.d, b.l, b.dst});
          chk("alt_dest", {a_tvalid, a_tdest}, {1'b1, b.alt});
        end
      end
      stall_q = m_tvalid && !m_tready;
      prev = {m_tdata, m_tlast, m_tdest};
    end
  end

  initial begin
    logic [7:0] f[$];
    for (int c = 0; c < 4; c++) cls_cnt[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", m_tvalid, 32'd0);
    chk("rst_sready", s_tready, 32'd0);
    chk("rst_out", {m_tdata, m_tlast, m_tdest}, 32'd0);
    chk("rst_alt_dest", a_tdest, 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    mk(f, 64, 1, 3'd5); send_frame(f, 0); wait_drain();
    mk(f, 60, 0, 3'd0); send_frame(f, 1);
    mk(f, 10, 0, 3'd0); send_frame(f, 0);
    chk("drain_sready", s_tready, 32'd0);
    chk("drain_mvalid", m_tvalid, 32'd1);
    wait_drain();

    rdy_mode = 1;
    mk(f, 40, 1, 3'd7); send_frame(f, 0); wait_drain();
    rdy_mode = 2;
    mk(f, 20, 1, 3'd1); send_frame(f, 0);
    mk(f, 20, 1, 3'd6); send_frame(f, 0);
    mk(f, 1, 3, 3'd0);  send_frame(f, 0);
    mk(f, 15, 1, 3'd4); send_frame(f, 0);
    mk(f, 14, 1, 3'd0); send_frame(f, 0);
    mk(f, 16, 1, 3'd0); send_frame(f, 0);
    mk(f, 30, 2, 3'd7); send_frame(f, 0);
    wait_drain();
    chk_stats();

    // Reset while the header of a PCP6 frame is stuck in the drain buffer.
    rdy_mode = 3;
    mk(f, 30, 1, 3'd6);
    for (int i = 0; i < 15; i++) send_byte(f[i], 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("stuck_mvalid", m_tvalid, 32'd1);
    chk("stuck_dest", m_tdest, 32'd3);
    rstn = 1'b0;
    #1;
    chk("midrst_mvalid", m_tvalid, 32'd0);
    chk("midrst_dest", m_tdest, 32'd0);
    chk("midrst_sready", s_tready, 32'd0);
    expq.delete();
    for (int c = 0; c < 4; c++) cls_cnt[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 0;
    mk(f, 25, 1, 3'd2); send_frame(f, 1); wait_drain();

    for (int k = 0; k < 30; k++) begin
      mk(f, $urandom_range(1, 50), $urandom_range(0, 3), 3'($urandom));
      send_frame(f, 1);
      if (k == 15) rdy_mode = 1;
    end
    wait_drain();
    chk_stats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
